// File: rtl/load_store_unit.sv
// load_store_unit
//   Load/store initiator between the RV32I execute stage and a word-wide data
//   memory (DataM) that has no byte enables. The unit accepts one request per
//   handshake. Sub-word stores are performed as read-modify-write. Load data is
//   sign- or zero-extended and returned as a one-cycle response pulse.
//
//   Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned
//   halfword/word accesses. When it is undefined, misaligned low address bits
//   are ignored.
//
// Ports
//   CLK, RST                 clock; synchronous active-high reset
//   ReqValid/ReqReady        request handshake (ReqReady is high only in IDLE)
//   ReqWrite, ReqFunct3      store flag and RV32I funct3 (B/H/W/BU/HU)
//   ReqAddr, ReqWData        byte address and store data
//   RspValid                 one-cycle response pulse
//   RspRData                 extended load data (0 for stores and faults)
//   RspFault                 illegal funct3 or misaligned access
//   MemAddress               word-aligned address to DataM
//   MemWriteData, MemWrite   write data and write strobe to DataM
//   MemReadData              read data from DataM (MEM_RD_LAT = 0 or 1)
module load_store_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspRData,
  output logic        RspFault,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        fault_q, fault_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic req_illegal;
  logic req_misalign;

  // Extracts the addressed byte/half from a word and extends it per funct3.
  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [1:0]  a,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b100:  extract_load = {24'h0, b};
      3'b101:  extract_load = {16'h0, h};
      default: extract_load = w;
    endcase
  endfunction

  // Replaces the target byte (addr[1:0]) or half (addr[1]) lane of a word.
  function automatic logic [31:0] merge_store(input logic [31:0] w,
                                              input logic [1:0]  a,
                                              input logic [2:0]  f3,
                                              input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) r[{a, 3'b000} +: 8] = d[7:0];
    else                  r[{a[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  // Stores only have B/H/W encodings; loads additionally have BU/HU.
  always_comb begin
    if (ReqWrite) req_illegal = ReqFunct3[2] || (ReqFunct3[1:0] == 2'b11);
    else          req_illegal = (ReqFunct3 == 3'b011) || (ReqFunct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misalign = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0]) ||
                   ((ReqFunct3[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
  end
`else
  always_comb begin
    req_misalign = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          write_d   = ReqWrite;
          funct3_d  = ReqFunct3;
          addr_lo_d = ReqAddr[1:0];
          wdata_d   = ReqWData[15:0];
          if (req_illegal || req_misalign) begin
            // Faults never touch memory, so the memory-side registers keep their values.
            fault_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            fault_d    = 1'b0;
            mem_addr_d = {ReqAddr[31:2], 2'b00};
            if (ReqWrite && (ReqFunct3[1:0] == 2'b10)) mem_wdata_d = ReqWData;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (write_q && (funct3_q[1:0] == 2'b10)) begin
          state_d = ST_RESP;
        end else if (MEM_RD_LAT == 0) begin
          word_d      = MemReadData;
          mem_wdata_d = merge_store(MemReadData, addr_lo_q, funct3_q, wdata_q);
          state_d     = write_q ? ST_WRITE : ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        word_d      = MemReadData;
        mem_wdata_d = merge_store(MemReadData, addr_lo_q, funct3_q, wdata_q);
        state_d     = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 16'h0;
      word_q      <= 32'h0;
      fault_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    ReqReady     = (state_q == ST_IDLE);
    RspValid     = (state_q == ST_RESP);
    RspFault     = (state_q == ST_RESP) && fault_q;
    RspRData     = 32'h0;
    if ((state_q == ST_RESP) && !fault_q && !write_q)
      RspRData = extract_load(word_q, addr_lo_q, funct3_q);
    MemAddress   = mem_addr_q;
    MemWriteData = mem_wdata_q;
    // SW writes straight from ACCESS; sub-word stores write once in WRITE.
    MemWrite     = ((state_q == ST_ACCESS) && write_q && (funct3_q[1:0] == 2'b10)) ||
                   (state_q == ST_WRITE);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a one-cycle-latency data memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [2:0]  ReqFunct3 = 3'b000;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWData = 32'h0;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        RspFault;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic [31:0] MemReadData;

  int checkCount = 0;
  int failCount = 0;
  int writeCount = 0;

  logic [31:0] mem [0:63];
  logic        preloadWe = 1'b0;
  logic [5:0]  preloadIdx = 6'd0;
  logic [31:0] preloadData = 32'h0;

  load_store_unit #(.MEM_RD_LAT(1)) dut (
    .CLK(CLK), .RST(RST),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspRData(RspRData), .RspFault(RspFault),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 CLK = ~CLK;

  // Data memory with registered read (one cycle latency) and a bench preload port.
  always @(posedge CLK) begin
    if (preloadWe) mem[preloadIdx] <= preloadData;
    else if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
    MemReadData <= mem[MemAddress[7:2]];
  end

  always @(posedge CLK) begin
    if (MemWrite) writeCount <= writeCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic preloadWord(input logic [5:0] idx, input logic [31:0] data);
    preloadIdx  = idx;
    preloadData = data;
    preloadWe   = 1'b1;
    @(negedge CLK);
    preloadWe   = 1'b0;
  endtask

  // Issues one request (starting at a negedge) and waits for its response.
  // lat is the cycle offset from the accept cycle N to the RspValid cycle.
  task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output int lat, output logic [31:0] rdata,
                               output logic fault, output int writes);
    int guard;
    int baseWrites;
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqFunct3 = f3;
    ReqAddr   = addr;
    ReqWData  = wd;
    guard = 0;
    while (!ReqReady && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    baseWrites = writeCount;
    @(posedge CLK);
    @(negedge CLK);
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    rdata  = RspRData;
    fault  = RspFault;
    writes = writeCount - baseWrites;
  endtask

  initial begin
    int          lat;
    int          writes;
    int          baseWrites;
    logic [31:0] rdata;
    logic        fault;
    logic        seenRsp;

    @(negedge CLK);
    preloadWord(6'd4, 32'h8081_7F01);
    preloadWord(6'd8, 32'h1122_3344);
    preloadWord(6'd9, 32'h0000_0000);
    @(negedge CLK);
    RST = 1'b0;

    checkOutput("rst_ready",  {31'h0, ReqReady}, 32'h1);
    checkOutput("rst_valid",  {31'h0, RspValid}, 32'h0);
    checkOutput("rst_rdata",  RspRData, 32'h0);
    checkOutput("rst_fault",  {31'h0, RspFault}, 32'h0);
    checkOutput("rst_mwrite", {31'h0, MemWrite}, 32'h0);
    checkOutput("rst_maddr",  MemAddress, 32'h0);
    checkOutput("rst_mwdata", MemWriteData, 32'h0);

    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, lat, rdata, fault, writes);
    checkOutput("lb13_data",  rdata, 32'hFFFF_FF80);
    checkOutput("lb13_lat",   lat, 3);
    checkOutput("lb13_fault", {31'h0, fault}, 32'h0);
    checkOutput("lb13_maddr", MemAddress, 32'h10);
    checkOutput("lb13_wr",    writes, 0);

    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, lat, rdata, fault, writes);
    checkOutput("lhu12_data", rdata, 32'h0000_8081);
    checkOutput("lhu12_lat",  lat, 3);

    applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, lat, rdata, fault, writes);
    checkOutput("lh10_data",  rdata, 32'h0000_7F01);

    applyStimulus(1'b0, 3'b100, 32'h11, 32'h0, lat, rdata, fault, writes);
    checkOutput("lbu11_data", rdata, 32'h0000_007F);

    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, lat, rdata, fault, writes);
    checkOutput("lh12_data",  rdata, 32'hFFFF_8081);

    applyStimulus(1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB, lat, rdata, fault, writes);
    checkOutput("sb21_lat",   lat, 4);
    checkOutput("sb21_wr",    writes, 1);
    checkOutput("sb21_fault", {31'h0, fault}, 32'h0);
    checkOutput("sb21_rdata", rdata, 32'h0);
    checkOutput("sb21_mem",   mem[8], 32'h1122_AB44);

    applyStimulus(1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, lat, rdata, fault, writes);
    checkOutput("sw24_lat",   lat, 2);
    checkOutput("sw24_wr",    writes, 1);
    checkOutput("sw24_mem",   mem[9], 32'hDEAD_BEEF);

    applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, lat, rdata, fault, writes);
    checkOutput("lw24_data",  rdata, 32'hDEAD_BEEF);
    checkOutput("lw24_lat",   lat, 3);

    applyStimulus(1'b0, 3'b010, 32'h26, 32'h0, lat, rdata, fault, writes);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("lw26_fault", {31'h0, fault}, 32'h1);
    checkOutput("lw26_lat",   lat, 1);
    checkOutput("lw26_data",  rdata, 32'h0);
`else
    checkOutput("lw26_fault", {31'h0, fault}, 32'h0);
    checkOutput("lw26_lat",   lat, 3);
    checkOutput("lw26_data",  rdata, 32'hDEAD_BEEF);
`endif
    checkOutput("lw26_wr",    writes, 0);

    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, lat, rdata, fault, writes);
    checkOutput("f011_fault", {31'h0, fault}, 32'h1);
    checkOutput("f011_lat",   lat, 1);
    checkOutput("f011_data",  rdata, 32'h0);
    checkOutput("f011_wr",    writes, 0);

    applyStimulus(1'b1, 3'b100, 32'h20, 32'h1234_5678, lat, rdata, fault, writes);
    checkOutput("sbu_fault",  {31'h0, fault}, 32'h1);
    checkOutput("sbu_wr",     writes, 0);
    checkOutput("sbu_mem",    mem[8], 32'h1122_AB44);

    applyStimulus(1'b1, 3'b001, 32'h22, 32'h0000_5566, lat, rdata, fault, writes);
    checkOutput("sh22_lat",   lat, 4);
    checkOutput("sh22_mem",   mem[8], 32'h5566_AB44);

    // SH aborted by reset while waiting for read data.
    @(negedge CLK);
    ReqValid  = 1'b1;
    ReqWrite  = 1'b1;
    ReqFunct3 = 3'b001;
    ReqAddr   = 32'h20;
    ReqWData  = 32'h0000_9999;
    checkOutput("abort_ready0", {31'h0, ReqReady}, 32'h1);
    baseWrites = writeCount;
    @(posedge CLK);
    @(negedge CLK);
    ReqValid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort_ready", {31'h0, ReqReady}, 32'h1);
    seenRsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (RspValid) seenRsp = 1'b1;
      @(negedge CLK);
    end
    checkOutput("abort_rsp",  {31'h0, seenRsp}, 32'h0);
    checkOutput("abort_wr",   writeCount - baseWrites, 0);
    checkOutput("abort_mem",  mem[8], 32'h5566_AB44);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
